gp_spi_master: RTL
==================

Name: gp_spi_master

Overview:
- SPI initiator (mode 0: CPOL=0, CPHA=0) that drives the GreenPAK4 hard SPI slave (GP_SPI) or any external SPI responder from user fabric.
- Accepts a parallel word over a valid/ready handshake, shifts it out on MOSI while shifting MISO in, then returns the received word with a one-cycle valid pulse.
- Sits between user logic and the GP_IOBUF/GP_OBUFT pad cells; it is pure fabric logic built from DFFs, LUTs and counters.

Parameters:
- WIDTH, 8, bits per transfer; legal range 2..16.
- CLKDIV, 4, CLK cycles per SCK half-period; legal range 1..255.
- MSB_FIRST, 1'b1, 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.

Ports:
- CLK  input  1  system clock; all logic is rising-edge.
- RST  input  1  reset, asynchronous and active-high.
- TX_DATA  input  WIDTH  word to transmit; sampled only on accept.
- TX_VALID  input  1  request to start a transfer.
- TX_READY  output  1  high only in IDLE.
- RX_DATA  output  WIDTH  last received word; holds its value until the next completed transfer.
- RX_VALID  output  1  one-cycle pulse when RX_DATA updates.
- BUSY  output  1  high in every state except IDLE.
- SCK  output  1  serial clock; idles low.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in; treated as synchronous to CLK.
- nCSB  output  1  chip select, active-low.

Behaviour:
- All outputs and state are registered. Reset values: SCK=0, MOSI=0, nCSB=1, TX_READY=1, BUSY=0, RX_VALID=0, RX_DATA=0. State=IDLE, divider=0, bit counter=0.
- Divider counts 0..CLKDIV-1. A phase ends on the cycle the divider reaches CLKDIV-1; the divider then reloads to 0.
- IDLE:
  - On TX_VALID&TX_READY at a rising edge: latch TX_DATA; on that same edge drive nCSB=0 and MOSI=first bit; go SETUP.
  - Handshake transfer is exactly one cycle. TX_VALID outside IDLE is ignored, with no queueing.
- SETUP (CLKDIV cycles): SCK=0. At phase end: SCK<=1, capture MISO into the receive shift register; go HIGH.
- HIGH (CLKDIV cycles): at phase end: SCK<=0, bit counter++.
  - If counter was WIDTH-1: go HOLD.
  - Otherwise: MOSI<=next bit; go LOW.
- LOW (CLKDIV cycles): at phase end: SCK<=1, capture MISO; go HIGH.
- HOLD (CLKDIV cycles): SCK=0, MOSI holds the last bit. At phase end: nCSB<=1, MOSI<=0, RX_DATA<=shift register, RX_VALID<=1 for one cycle; go GAP.
- GAP (CLKDIV cycles): nCSB=1. At phase end go IDLE, where TX_READY=1 on the next cycle.
- Timing:
  - nCSB low for exactly (2*WIDTH+1)*CLKDIV cycles.
  - Exactly WIDTH SCK rising edges per transfer.
  - Minimum nCSB-high gap between transfers is CLKDIV+1 cycles (GAP plus the IDLE accept cycle).
- Bit order:
  - MSB_FIRST=1: first MOSI bit is TX_DATA[WIDTH-1]; the first captured MISO bit lands in RX_DATA[WIDTH-1].
  - MSB_FIRST=0: mirror of the above, using bit 0 for both.
- Changes to TX_DATA after accept have no effect.
- Reset asserted mid-transfer: all outputs take their reset values asynchronously, with no RX_VALID for the aborted word. After release, the block starts in IDLE.
- CLKDIV=1: each phase is a single cycle; the FSM operates without stall states.
- Parameters outside their legal range are not supported.

Test Plan:
- Reset check: assert RST mid-simulation with arbitrary inputs -> immediately SCK=0, nCSB=1, MOSI=0, TX_READY=1, RX_VALID=0, RX_DATA=0.
- Loopback, defaults (MISO tied to MOSI), send 0xA5 -> 8 SCK rising edges; MOSI sequence 1,0,1,0,0,1,0,1; nCSB low 68 cycles; RX_VALID pulses once with RX_DATA=0xA5 on the nCSB-rising cycle.
- Slave model returning 0x3C while sending 0xFF, MSB_FIRST=0 -> MOSI all ones; MISO bits sent LSB-first; RX_DATA=0x3C.
- TX_VALID held high, two words 0x12 then 0x34 -> second accept exactly CLKDIV+1 cycles after nCSB rises (5 cycles); two RX_VALID pulses; TX_DATA changes during transfer 1 ignored.
- Reset asserted 20 cycles after accept -> SCK/nCSB/MOSI return to idle in the same cycle; no RX_VALID; a new transfer after release completes normally.
- CLKDIV=1, WIDTH=16, loopback 0xBEEF -> nCSB low 33 cycles; SCK toggles every cycle; RX_DATA=0xBEEF.

Source files
------------

// File: rtl/gp_spi_master.sv
// Mode-0 SPI initiator: accepts a word over valid/ready, shifts it out on MOSI
// while sampling MISO, and returns the received word with a one-cycle RX_VALID.
module gp_spi_master #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CLKDIV    = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             RX_VALID,
    output logic             BUSY,
    output logic             SCK,
    output logic             MOSI,
    input  logic             MISO,
    output logic             nCSB
);

    localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_HOLD,
        S_GAP
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div, div_d;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
    logic [WIDTH-1:0] tx_sh, tx_sh_d;
    logic [WIDTH-1:0] rx_sh, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             ncsb_q, ncsb_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_ready_q, busy_q;
    logic             phase_end;
    logic [WIDTH-1:0] tx_load;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) r[i] = v[int'(WIDTH) - 1 - i];
        return r;
    endfunction

    // Both shift registers always move MSB-ward; LSB-first order is a bit reversal at the edges.
    assign tx_load   = MSB_FIRST ? TX_DATA : bit_rev(TX_DATA);
    assign phase_end = (div == DIV_LAST);

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        div_d      = div;
        bit_cnt_d  = bit_cnt;
        tx_sh_d    = tx_sh;
        rx_sh_d    = rx_sh;
        rx_data_d  = rx_data_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        ncsb_d     = ncsb_q;
        rx_valid_d = 1'b0;

        if (state != S_IDLE) div_d = phase_end ? '0 : div + DIV_W'(1);

        case (state)
            S_IDLE: begin
                if (TX_VALID && tx_ready_q) begin
                    state_d   = S_SETUP;
                    div_d     = '0;
                    bit_cnt_d = '0;
                    ncsb_d    = 1'b0;
                    mosi_d    = tx_load[WIDTH-1];
                    tx_sh_d   = {tx_load[WIDTH-2:0], tx_load[WIDTH-1]};
                end
            end
            S_SETUP, S_LOW: begin
                if (phase_end) begin
                    sck_d   = 1'b1;
                    rx_sh_d = {rx_sh[WIDTH-2:0], MISO};
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    sck_d     = 1'b0;
                    bit_cnt_d = bit_cnt + CNT_W'(1);
                    if (bit_cnt == BIT_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        mosi_d  = tx_sh[WIDTH-1];
                        tx_sh_d = {tx_sh[WIDTH-2:0], tx_sh[WIDTH-1]};
                        state_d = S_LOW;
                    end
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    ncsb_d     = 1'b1;
                    mosi_d     = 1'b0;
                    rx_data_d  = MSB_FIRST ? rx_sh : bit_rev(rx_sh);
                    rx_valid_d = 1'b1;
                    state_d    = S_GAP;
                end
            end
            S_GAP: begin
                if (phase_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            div        <= '0;
            bit_cnt    <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            ncsb_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_d;
            div        <= div_d;
            bit_cnt    <= bit_cnt_d;
            tx_sh      <= tx_sh_d;
            rx_sh      <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            ncsb_q     <= ncsb_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= (state_d == S_IDLE);
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign TX_READY = tx_ready_q;
    assign BUSY     = busy_q;
    assign RX_DATA  = rx_data_q;
    assign RX_VALID = rx_valid_q;
    assign SCK      = sck_q;
    assign MOSI     = mosi_q;
    assign nCSB     = ncsb_q;

endmodule
